// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared definitions for the multi-channel common data bus arbiter:
// default sizes, broadcast channel payload types and a pointer-width helper.
package cdb_rr_arbiter_pkg;

    localparam int unsigned NUM_FU_DEF  = 8;
    localparam int unsigned NUM_CDB_DEF = 2;
    localparam int unsigned TAG_W_DEF   = 5;
    localparam int unsigned XLEN_DEF    = 32;

    // One broadcast channel as seen by the RS/ROB/map-table consumers.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]  value;
    } cdb_channel_t;

    typedef cdb_channel_t [NUM_CDB_DEF-1:0] cdb_multi_packet_t;

    // Index width for an n-entry rotating pointer; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_arbiter_rr_pick.sv
// Rotating-priority one-hot picker: grants the first requester found when
// scanning upward from ptr and wrapping around to index 0.
module rr_pick
    import cdb_rr_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_FU = NUM_FU_DEF,
    localparam int unsigned PTR_W  = ptr_width(NUM_FU)
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_FU-1:0] gnt
);

    logic             found;
    logic [PTR_W-1:0] pos;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned j = 0; j < NUM_FU; j++) begin
            pos = PTR_W'((32'(ptr) + j) % NUM_FU);
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// N-channel common data bus arbiter: round-robin grants of completed FUs onto
// NUM_CDB registered broadcast channels, with squash and async reset.
module cdb_rr_arbiter
    import cdb_rr_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_FU  = NUM_FU_DEF,
    parameter  int unsigned NUM_CDB = NUM_CDB_DEF,
    parameter  int unsigned TAG_W   = TAG_W_DEF,
    parameter  int unsigned XLEN    = XLEN_DEF,
    localparam int unsigned PTR_W   = ptr_width(NUM_FU)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic [NUM_FU-1:0]        fu_done,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*XLEN-1:0]   fu_value,
    output logic [NUM_FU-1:0]        fu_ack,
    output logic [NUM_CDB-1:0]       cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    output logic [NUM_CDB*XLEN-1:0]  cdb_value,
    output logic [PTR_W-1:0]         rr_ptr_dbg
);

    logic [PTR_W-1:0]                 rr_ptr;
    logic [NUM_CDB-1:0][NUM_FU-1:0]   chan_gnt;
    logic [NUM_FU-1:0]                last_gnt;
    logic [PTR_W-1:0]                 last_idx;
    logic [PTR_W-1:0]                 ptr_next;
    logic [NUM_CDB-1:0]               ch_valid;
    logic [NUM_CDB*TAG_W-1:0]         ch_tag;
    logic [NUM_CDB*XLEN-1:0]          ch_value;

    // Cascade of pickers; each stage sees only requesters not yet granted upstream.
    for (genvar k = 0; k < NUM_CDB; k++) begin : g_stage
        logic [NUM_FU-1:0] req_k;
        logic [NUM_FU-1:0] gnt_k;

        if (k == 0) begin : g_first
            assign req_k = fu_done;
        end else begin : g_next
            assign req_k = g_stage[k-1].req_k & ~g_stage[k-1].gnt_k;
        end

        rr_pick #(
            .NUM_FU (NUM_FU)
        ) u_pick (
            .req (req_k),
            .ptr (rr_ptr),
            .gnt (gnt_k)
        );

        assign chan_gnt[k] = gnt_k;
    end

    // Channel payload muxing, acks, and the last-granted FU for the pointer update.
    always_comb begin
        fu_ack   = '0;
        last_gnt = '0;
        last_idx = '0;
        ch_valid = '0;
        ch_tag   = '0;
        ch_value = '0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            ch_valid[k] = |chan_gnt[k];
            fu_ack      = fu_ack | chan_gnt[k];
            if (ch_valid[k]) begin
                last_gnt = chan_gnt[k];
            end
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (chan_gnt[k][i]) begin
                    ch_tag[k*TAG_W +: TAG_W] = fu_tag[i*TAG_W +: TAG_W];
                    ch_value[k*XLEN +: XLEN] = fu_value[i*XLEN +: XLEN];
                end
            end
        end
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (last_gnt[i]) begin
                last_idx = PTR_W'(i);
            end
        end
        // A squash or reset kills the whole cycle's grant, so nothing is acked or broadcast.
        if (squash || reset) begin
            fu_ack   = '0;
            ch_valid = '0;
            ch_tag   = '0;
            ch_value = '0;
        end
    end

    assign ptr_next = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + PTR_W'(1);

    // Broadcast registers and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= ch_valid;
            cdb_tag   <= ch_tag;
            cdb_value <= ch_value;
            if (|ch_valid) begin
                rr_ptr <= ptr_next;
            end
        end
    end

    assign rr_ptr_dbg = rr_ptr;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter (8 FUs, 2 channels): reset, single grant,
// full contention, wrap-around, squash and asynchronous reset mid-burst.
module tb_cdb_rr_arbiter;

    localparam int unsigned NUM_FU  = 8;
    localparam int unsigned NUM_CDB = 2;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned XLEN    = 32;

    logic                     clock;
    logic                     reset;
    logic                     squash;
    logic [NUM_FU-1:0]        fu_done;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*XLEN-1:0]   fu_value;
    logic [NUM_FU-1:0]        fu_ack;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_value;
    logic [2:0]               rr_ptr_dbg;

    int n_cmp = 0;
    int n_err = 0;

    cdb_rr_arbiter #(
        .NUM_FU  (NUM_FU),
        .NUM_CDB (NUM_CDB),
        .TAG_W   (TAG_W),
        .XLEN    (XLEN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .fu_done    (fu_done),
        .fu_tag     (fu_tag),
        .fu_value   (fu_value),
        .fu_ack     (fu_ack),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .rr_ptr_dbg (rr_ptr_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // FU i carries tag 16+i and value 0xC0DE0000+i unless a test overrides it.
    task automatic load_payload();
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i*TAG_W +: TAG_W]  = 5'(16 + i);
            fu_value[i*XLEN +: XLEN] = 32'hC0DE_0000 + 32'(i);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #2;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({fu_ack, cdb_valid, rr_ptr_dbg} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_async: ack/valid/ptr got %h expected 0", {fu_ack, cdb_valid, rr_ptr_dbg});
        end
        n_cmp++;
        if ({cdb_tag, cdb_value} !== 74'd0) begin
            n_err++;
            $display("FAIL reset_payload: tag/value got %h expected 0", {cdb_tag, cdb_value});
        end
        fu_done = 8'hFF;
        #1;
        n_cmp++;
        if (fu_ack !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ack_gated: ack got %h expected 00", fu_ack);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, rr_ptr_dbg} !== 5'd0) begin
            n_err++;
            $display("FAIL reset_held: valid/ptr got %h expected 0", {cdb_valid, rr_ptr_dbg});
        end
        @(negedge clock);
        fu_done = 8'h00;
        reset   = 1'b0;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            n_cmp++;
            if (fu_ack !== 8'h00) begin
                n_err++;
                $display("FAIL idle_ack: cycle %0d got %h expected 00", c, fu_ack);
            end
            @(posedge clock);
            #1;
            n_cmp++;
            if ({cdb_valid, rr_ptr_dbg} !== 5'd0) begin
                n_err++;
                $display("FAIL idle_state: cycle %0d valid/ptr got %h expected 0", c, {cdb_valid, rr_ptr_dbg});
            end
        end
    endtask

    task automatic test_single();
        @(negedge clock);
        fu_tag[15 +: 5]   = 5'd7;
        fu_value[96 +: 32] = 32'h0000_DEAD;
        fu_done = 8'b0000_1000;
        #1;
        n_cmp++;
        if (fu_ack !== 8'b0000_1000) begin
            n_err++;
            $display("FAIL single_ack: got %b expected 00001000", fu_ack);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, cdb_tag, rr_ptr_dbg} !== {2'b01, 5'd0, 5'd7, 3'd4}) begin
            n_err++;
            $display("FAIL single_bcast: valid/tag/ptr got %b_%h_%0d expected 01_007_4", cdb_valid, cdb_tag, rr_ptr_dbg);
        end
        n_cmp++;
        if (cdb_value !== {32'h0, 32'h0000_DEAD}) begin
            n_err++;
            $display("FAIL single_value: got %h expected 000000000000dead", cdb_value);
        end
        @(negedge clock);
        fu_done = 8'h00;
        load_payload();
        #1;
        n_cmp++;
        if (fu_ack !== 8'h00) begin
            n_err++;
            $display("FAIL single_release_ack: got %h expected 00", fu_ack);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, cdb_tag, rr_ptr_dbg} !== {2'b00, 10'd0, 3'd4}) begin
            n_err++;
            $display("FAIL single_after: valid/tag/ptr got %b_%h_%0d expected 00_000_4", cdb_valid, cdb_tag, rr_ptr_dbg);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_ack [4] = '{8'h03, 8'h0C, 8'h30, 8'hC0};
        logic [2:0] exp_ptr [4] = '{3'd2, 3'd4, 3'd6, 3'd0};
        logic [7:0] remaining;
        logic [7:0] acked;
        logic [7:0] seen;
        int         dup;
        int         idx;
        do_reset();
        remaining = 8'hFF;
        seen      = 8'h00;
        dup       = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            fu_done = remaining;
            #1;
            acked = fu_ack;
            n_cmp++;
            if (fu_ack !== exp_ack[c]) begin
                n_err++;
                $display("FAIL contention_ack: cycle %0d got %h expected %h", c, fu_ack, exp_ack[c]);
            end
            @(posedge clock);
            #1;
            n_cmp++;
            if ({cdb_valid, cdb_tag, rr_ptr_dbg} !== {2'b11, 5'(17 + 2*c), 5'(16 + 2*c), exp_ptr[c]}) begin
                n_err++;
                $display("FAIL contention_bcast: cycle %0d valid/tag/ptr got %b_%h_%0d expected 11_%h_%0d",
                         c, cdb_valid, cdb_tag, rr_ptr_dbg, {5'(17 + 2*c), 5'(16 + 2*c)}, exp_ptr[c]);
            end
            for (int k = 0; k < NUM_CDB; k++) begin
                if (cdb_valid[k]) begin
                    idx = int'(cdb_tag[k*TAG_W +: TAG_W]) - 16;
                    if (idx >= 0 && idx < NUM_FU) begin
                        if (seen[idx]) dup++;
                        seen[idx] = 1'b1;
                    end
                end
            end
            remaining = remaining & ~acked;
        end
        @(negedge clock);
        fu_done = remaining;
        #1;
        n_cmp++;
        if (fu_ack !== 8'h00) begin
            n_err++;
            $display("FAIL contention_drained_ack: got %h expected 00", fu_ack);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, rr_ptr_dbg} !== {2'b00, 3'd0}) begin
            n_err++;
            $display("FAIL contention_idle: valid/ptr got %b_%0d expected 00_0", cdb_valid, rr_ptr_dbg);
        end
        n_cmp++;
        if ({seen, 8'(dup)} !== {8'hFF, 8'd0}) begin
            n_err++;
            $display("FAIL contention_once: seen/dup got %h/%0d expected ff/0", seen, dup);
        end
    endtask

    task automatic test_wrap();
        @(negedge clock);
        fu_done = 8'h40;
        #1;
        n_cmp++;
        if (fu_ack !== 8'h40) begin
            n_err++;
            $display("FAIL wrap_setup_ack: got %h expected 40", fu_ack);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (rr_ptr_dbg !== 3'd7) begin
            n_err++;
            $display("FAIL wrap_setup_ptr: got %0d expected 7", rr_ptr_dbg);
        end
        @(negedge clock);
        fu_done = 8'h81;
        #1;
        n_cmp++;
        if (fu_ack !== 8'h81) begin
            n_err++;
            $display("FAIL wrap_ack: got %h expected 81", fu_ack);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, cdb_tag, rr_ptr_dbg} !== {2'b11, 5'd16, 5'd23, 3'd1}) begin
            n_err++;
            $display("FAIL wrap_bcast: valid/tag/ptr got %b_%h_%0d expected 11_%h_1", cdb_valid, cdb_tag, rr_ptr_dbg, {5'd16, 5'd23});
        end
        n_cmp++;
        if (cdb_value !== {32'hC0DE_0000, 32'hC0DE_0007}) begin
            n_err++;
            $display("FAIL wrap_value: got %h expected c0de0000c0de0007", cdb_value);
        end
        @(negedge clock);
        fu_done = 8'h00;
    endtask

    task automatic test_squash();
        @(negedge clock);
        fu_done = 8'h20;
        #1;
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, rr_ptr_dbg} !== {2'b01, 3'd6}) begin
            n_err++;
            $display("FAIL squash_setup: valid/ptr got %b_%0d expected 01_6", cdb_valid, rr_ptr_dbg);
        end
        @(negedge clock);
        fu_done = 8'h06;
        squash  = 1'b1;
        #1;
        n_cmp++;
        if ({fu_ack, cdb_valid} !== {8'h00, 2'b01}) begin
            n_err++;
            $display("FAIL squash_ack: ack/valid got %h_%b expected 00_01", fu_ack, cdb_valid);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, cdb_tag, rr_ptr_dbg} !== {2'b00, 10'd0, 3'd6}) begin
            n_err++;
            $display("FAIL squash_flush: valid/tag/ptr got %b_%h_%0d expected 00_000_6", cdb_valid, cdb_tag, rr_ptr_dbg);
        end
        @(negedge clock);
        squash = 1'b0;
        #1;
        n_cmp++;
        if (fu_ack !== 8'h06) begin
            n_err++;
            $display("FAIL squash_resume_ack: got %h expected 06", fu_ack);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, cdb_tag, rr_ptr_dbg} !== {2'b11, 5'd18, 5'd17, 3'd3}) begin
            n_err++;
            $display("FAIL squash_resume_bcast: valid/tag/ptr got %b_%h_%0d expected 11_%h_3", cdb_valid, cdb_tag, rr_ptr_dbg, {5'd18, 5'd17});
        end
        @(negedge clock);
        fu_done = 8'h00;
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        fu_done = 8'hFF;
        #1;
        n_cmp++;
        if (fu_ack !== 8'h18) begin
            n_err++;
            $display("FAIL burst_ack0: got %h expected 18", fu_ack);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, rr_ptr_dbg} !== {2'b11, 3'd5}) begin
            n_err++;
            $display("FAIL burst_bcast0: valid/ptr got %b_%0d expected 11_5", cdb_valid, rr_ptr_dbg);
        end
        @(negedge clock);
        fu_done = 8'hE7;
        #1;
        n_cmp++;
        if (fu_ack !== 8'h60) begin
            n_err++;
            $display("FAIL burst_ack1: got %h expected 60", fu_ack);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({fu_ack, cdb_valid, rr_ptr_dbg} !== 13'd0) begin
            n_err++;
            $display("FAIL async_clear: ack/valid/ptr got %h expected 0", {fu_ack, cdb_valid, rr_ptr_dbg});
        end
        n_cmp++;
        if ({cdb_tag, cdb_value} !== 74'd0) begin
            n_err++;
            $display("FAIL async_payload: tag/value got %h expected 0", {cdb_tag, cdb_value});
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, rr_ptr_dbg} !== 5'd0) begin
            n_err++;
            $display("FAIL async_dropped: valid/ptr got %h expected 0", {cdb_valid, rr_ptr_dbg});
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (fu_ack !== 8'h03) begin
            n_err++;
            $display("FAIL post_reset_ack: got %h expected 03", fu_ack);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, cdb_tag, rr_ptr_dbg} !== {2'b11, 5'd17, 5'd16, 3'd2}) begin
            n_err++;
            $display("FAIL post_reset_bcast: valid/tag/ptr got %b_%h_%0d expected 11_%h_2", cdb_valid, cdb_tag, rr_ptr_dbg, {5'd17, 5'd16});
        end
        @(negedge clock);
        fu_done = 8'h00;
        @(posedge clock);
        #1;
        n_cmp++;
        if ({cdb_valid, rr_ptr_dbg} !== {2'b00, 3'd2}) begin
            n_err++;
            $display("FAIL post_reset_idle: valid/ptr got %b_%0d expected 00_2", cdb_valid, rr_ptr_dbg);
        end
    endtask

    initial begin
        reset   = 1'b1;
        squash  = 1'b0;
        fu_done = '0;
        fu_tag  = '0;
        fu_value = '0;
        load_payload();
        test_reset();
        test_idle();
        test_single();
        test_contention();
        test_wrap();
        test_squash();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
